step_sequencer: RTL and testbench
=================================

# step_sequencer

Consumes the 4-bit step count produced by the switch priority encoder and turns it back into a staircase waveform. The selected count is decoded into a sequence of equally spaced output levels, each held for a programmable dwell time. The block drives the DAC/PWM level code and a thermometer LED bar on the Basys 3. It sits directly downstream of the step selector in the Step Generator datapath.

## Interface
- `DWELL_CYCLES`, default 100_000_000: clock cycles each level is held (1 s at 100 MHz); legal range ≥ 2.
- `LEVEL_W`, default 8: width of the output level code.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request, level-sensitive.
- `steps`  in  4  requested step count, 0–10; values 11–15 clamp to 10.
- `level`  out  LEVEL_W  current staircase level code.
- `step_idx`  out  4  current step index, 0 .. N-1.
- `leds`  out  10  thermometer of the current step: bits [step_idx:0] set.
- `step_tick`  out  1  one-cycle pulse on every level change.
- `wrap`  out  1  one-cycle pulse when the index returns from N-1 to 0.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-high.
- States:
  - IDLE: all outputs 0, dwell counter held at 0.
  - RUN: staircase is running.
- IDLE→RUN: `enable`=1 and clamp(`steps`)≠0. On this edge, N latches clamp(`steps`), `step_idx`=0, dwell counter=0.
- RUN→IDLE: `enable`=0, evaluated every cycle with top priority. Also taken at a wrap if the newly sampled clamp(`steps`)=0.
- Dwell counter: counts 0..DWELL_CYCLES-1. At the terminal count, `step_idx` advances by 1 and `step_tick` pulses.
  - If `step_idx` was N-1, it goes to 0 and `wrap` pulses.
  - On that same edge, N re-latches clamp(`steps`).
- `steps` is sampled only on entering RUN and at wraps. Changes mid-staircase take effect after the current ramp finishes.
- Level arithmetic: `level` = (`step_idx`+1) × SS[N], where SS[N] = floor((2^LEVEL_W − 1)/N) comes from a package LUT.
  - The product is computed at LEVEL_W+4 bits and truncated to LEVEL_W bits. Truncation is lossless because the result is ≤ 2^LEVEL_W − 1.
  - N=1 gives a constant 255.
- `leds` = (2^(`step_idx`+1)) − 1 in RUN, 0 in IDLE.
- Simultaneous events:
  - `enable` fall coinciding with a wrap: IDLE wins, and `wrap` still pulses.
  - `reset` overrides everything, at any time.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Reset values: `level`=0, `step_idx`=0, `leds`=0, `step_tick`=0, `wrap`=0, state IDLE, N=0, dwell=0.
- Startup latency: `enable` sampled high at edge k → `level`=SS[N] and `step_idx`=0 valid after edge k.
- Each level is held exactly DWELL_CYCLES cycles. The full staircase period is N×DWELL_CYCLES.
- `step_tick` and `wrap` are high for exactly one cycle, coincident with the first cycle of the new level.
- `enable` low at edge k → all outputs 0 after edge k.
- Re-enable always restarts at `step_idx`=0.
- Mid-operation reset: outputs go to 0 asynchronously. The block resumes from IDLE on the first edge after release.

## Configuration
- `STEP_SEQ_LED_EN` defined: the thermometer decoder is compiled in and `leds` is driven as specified.
- Not defined: the decoder logic is omitted and `leds` is tied to 10'b0. All other behaviour is identical.

## Structure
- Shared header `step_defs.vh` contains:
  - `MAX_STEPS` = 10.
  - `STEPS_W` = 4.
  - The SS[1..10] step-size function/LUT (index 0 returns 0).
  - The state encodings (IDLE=1'b0, RUN=1'b1).
- The step selector and this block both use the `step_defs.vh` constants.
- Sub-module `dwell_timer`: parameterised terminal-count counter with sync clear and a one-cycle `tc` output. `step_sequencer` instantiates one.

## Test plan
Run with DWELL_CYCLES=4, LEVEL_W=8, `STEP_SEQ_LED_EN` defined.
1. `steps`=4, `enable`=1 → `level` 63,126,189,252, each held for 4 cycles, then 63 again with `wrap`=1 for one cycle. `leds` follow 0x001,0x003,0x007,0x00F.
2. `steps`=10 → levels 25,50,…,250; `step_tick` every 4 cycles; `leds`=0x3FF at `step_idx`=9.
3. `steps` changed 4→2 during `step_idx`=1 → the ramp completes 189,252, then 127,254 repeating.
4. `steps`=15 → behaves as 10 (top level 250). `steps`=0 with `enable`=1 → stays IDLE, `level`=0.
5. `enable` dropped at `step_idx`=2 → `level`=0 after the next edge. Re-enable → restarts at 63.
6. `reset` pulsed mid-dwell → all outputs 0 immediately (before the next edge). After release with `enable`=1 → 63 one edge later. Repeat with `STEP_SEQ_LED_EN` undefined → `leds` stay 0 throughout.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : step_sequencer_pkg
//  Description : Shared constants, state encoding and helper functions for
//                the step generator datapath (step count clamp and the
//                per-N step-size table SS[N] = floor((2^LEVEL_W-1)/N)).
//  Revision    : 1.0 - initial release
// ============================================================================
package step_sequencer_pkg;

  localparam int MAX_STEPS = 10;
  localparam int STEPS_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requests above MAX_STEPS saturate at MAX_STEPS.
  function automatic logic [STEPS_W-1:0] clamp_steps(input logic [STEPS_W-1:0] s);
    return (s > STEPS_W'(MAX_STEPS)) ? STEPS_W'(MAX_STEPS) : s;
  endfunction

  // Step size for an N-level staircase. Every division has a constant
  // divisor, so this reduces to a small constant LUT indexed by n.
  function automatic int unsigned step_size(input logic [STEPS_W-1:0] n,
                                            input int unsigned      lw);
    int unsigned full;
    int unsigned ss;
    full = (32'd1 << lw) - 32'd1;
    case (n)
      4'd1:    ss = full;
      4'd2:    ss = full / 2;
      4'd3:    ss = full / 3;
      4'd4:    ss = full / 4;
      4'd5:    ss = full / 5;
      4'd6:    ss = full / 6;
      4'd7:    ss = full / 7;
      4'd8:    ss = full / 8;
      4'd9:    ss = full / 9;
      4'd10:   ss = full / 10;
      default: ss = 0;
    endcase
    return ss;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : step_sequencer_if
//  Description : Control and output bundle of the step sequencer.
//                master : drives enable/steps, observes the staircase outputs
//                slave  : the sequencer itself
//  Signals     : enable    run request (level-sensitive)
//                steps     requested step count 0..15 (clamped to 10)
//                level     staircase level code, LEVEL_W bits
//                step_idx  current step index
//                leds      thermometer of the current step
//                step_tick one-cycle pulse on every level change
//                wrap      one-cycle pulse when the index returns to 0
//  Revision    : 1.0 - initial release
// ============================================================================
interface step_sequencer_if
  import step_sequencer_pkg::*;
#(
  parameter int LEVEL_W = 8
);
  logic                 enable;
  logic [STEPS_W-1:0]   steps;
  logic [LEVEL_W-1:0]   level;
  logic [STEPS_W-1:0]   step_idx;
  logic [MAX_STEPS-1:0] leds;
  logic                 step_tick;
  logic                 wrap;

  modport master (
    output enable, steps,
    input  level, step_idx, leds, step_tick, wrap
  );

  modport slave (
    input  enable, steps,
    output level, step_idx, leds, step_tick, wrap
  );
endinterface
`default_nettype wire

// File: rtl/step_sequencer_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_sequencer_dwell_timer
//  Description : Terminal-count counter 0..TC_CYCLES-1 with synchronous
//                clear. o_tc is high during the last count while enabled.
//  Ports       : clk, rst (async, active-high), i_clr (sync clear),
//                i_en (count enable), o_tc (terminal count)
//  Revision    : 1.0 - initial release
// ============================================================================
module step_sequencer_dwell_timer #(
  parameter int TC_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int                 c_CNT_W = (TC_CYCLES > 1) ? $clog2(TC_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TC_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Not gated by i_clr: a stop that coincides with the terminal count must
  // still see the terminal-count event (wrap pulse on a disable-at-wrap).
  assign o_tc = i_en && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + c_CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : step_sequencer
//  Description : Turns a step count N into a repeating staircase of levels
//                (idx+1)*SS[N], each held DWELL_CYCLES clocks. N is sampled
//                on start and at every wrap. All outputs are registered.
//  Ports       : clk    system clock
//                reset  asynchronous active-high reset
//                bus    step_sequencer_if.slave (enable, steps in;
//                       level, step_idx, leds, step_tick, wrap out)
//  Config      : STEP_SEQ_LED_EN - when defined, the thermometer LED decoder
//                is built; otherwise leds is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int LEVEL_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  step_sequencer_if.slave   bus
);
  localparam int c_PROD_W = LEVEL_W + 4;

  state_t               r_state;
  logic [STEPS_W-1:0]   r_n;
  logic [STEPS_W-1:0]   r_idx;
  logic [LEVEL_W-1:0]   r_level;
  logic                 r_step_tick;
  logic                 r_wrap;

  logic                 w_tc;
  logic                 w_last;
  logic                 w_load;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_step;
  logic [STEPS_W-1:0]   w_clamp;
  logic [STEPS_W-1:0]   w_tgt_n;
  logic [STEPS_W-1:0]   w_tgt_idx;
  logic [c_PROD_W-1:0]  w_prod;

  assign w_clamp = clamp_steps(bus.steps);
  assign w_last  = (r_idx == r_n - 4'd1);

  // Start and wrap both (re)load N from the input and restart at index 0;
  // otherwise the next level is simply the following index at the same N.
  assign w_load    = (r_state == ST_IDLE) || w_last;
  assign w_tgt_n   = w_load ? w_clamp : r_n;
  assign w_tgt_idx = w_load ? '0 : r_idx + 4'd1;
  assign w_prod    = (c_PROD_W'(w_tgt_idx) + c_PROD_W'(1))
                   * c_PROD_W'(step_size(w_tgt_n, LEVEL_W));

  assign w_start = (r_state == ST_IDLE) && bus.enable && (w_clamp != '0);
  assign w_stop  = (r_state == ST_RUN) &&
                   (!bus.enable || (w_tc && w_last && (w_clamp == '0)));
  assign w_step  = (r_state == ST_RUN) && w_tc && !w_stop;

  step_sequencer_dwell_timer #(
    .TC_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (reset),
    .i_clr ((r_state == ST_IDLE) || !bus.enable),
    .i_en  (r_state == ST_RUN),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_level     <= '0;
      r_step_tick <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      // A terminal count always produces its pulses, even when the block
      // stops on the same edge.
      r_step_tick <= (r_state == ST_RUN) && w_tc;
      r_wrap      <= (r_state == ST_RUN) && w_tc && w_last;
      if (w_stop) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_level <= '0;
      end else if (w_start || w_step) begin
        r_state <= ST_RUN;
        r_n     <= w_tgt_n;
        r_idx   <= w_tgt_idx;
        r_level <= w_prod[LEVEL_W-1:0];
      end
    end
  end

  assign bus.level     = r_level;
  assign bus.step_idx  = r_idx;
  assign bus.step_tick = r_step_tick;
  assign bus.wrap      = r_wrap;

`ifdef STEP_SEQ_LED_EN
  logic [MAX_STEPS-1:0] r_leds;
  logic [MAX_STEPS-1:0] w_tgt_leds;

  always_comb begin
    w_tgt_leds = '0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      w_tgt_leds[i] = (w_tgt_idx >= STEPS_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
    end else if (w_stop) begin
      r_leds <= '0;
    end else if (w_start || w_step) begin
      r_leds <= w_tgt_leds;
    end
  end

  assign bus.leds = r_leds;
`else
  assign bus.leds = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_sequencer
//  Description : Self-checking bench for step_sequencer (DWELL_CYCLES=4,
//                LEVEL_W=8). A behavioural model tracks run/N/index/dwell
//                from the staircase rules and every output is compared
//                one time unit after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;
  localparam int D  = 4;
  localparam int LW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  step_sequencer_if #(.LEVEL_W(LW)) bus ();

  step_sequencer #(
    .DWELL_CYCLES (D),
    .LEVEL_W      (LW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "reset";

  // Reference model state
  bit m_run;
  int m_n, m_idx, m_dw;
  bit m_tick, m_wrap;

  function automatic int clampv(input int s);
    return (s > 10) ? 10 : s;
  endfunction

  task automatic model_reset();
    m_run = 0; m_n = 0; m_idx = 0; m_dw = 0; m_tick = 0; m_wrap = 0;
  endtask

  // One rising edge of the reference, using the inputs present at the edge.
  task automatic model_clock();
    int  cs;
    bit  tc;
    cs = clampv(int'(bus.steps));
    if (reset) begin
      model_reset();
    end else if (!m_run) begin
      m_tick = 0; m_wrap = 0;
      if (bus.enable && cs != 0) begin
        m_run = 1; m_n = cs; m_idx = 0; m_dw = 0;
      end
    end else begin
      tc     = (m_dw == D - 1);
      m_tick = tc;
      m_wrap = tc && (m_idx == m_n - 1);
      if (!bus.enable) begin
        m_run = 0; m_idx = 0; m_dw = 0;
      end else if (tc) begin
        m_dw = 0;
        if (m_idx == m_n - 1) begin
          if (cs == 0) begin
            m_run = 0;
          end else begin
            m_n = cs; m_idx = 0;
          end
        end else begin
          m_idx = m_idx + 1;
        end
      end else begin
        m_dw = m_dw + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_level, exp_leds;
    exp_level = m_run ? (m_idx + 1) * (((1 << LW) - 1) / m_n) : 0;
`ifdef STEP_SEQ_LED_EN
    exp_leds  = m_run ? (1 << (m_idx + 1)) - 1 : 0;
`else
    exp_leds  = 0;
`endif
    check("level",     16'(bus.level),     16'(exp_level));
    check("step_idx",  16'(bus.step_idx),  16'(m_run ? m_idx : 0));
    check("leds",      16'(bus.leds),      16'(exp_leds));
    check("step_tick", 16'(bus.step_tick), 16'(m_tick));
    check("wrap",      16'(bus.wrap),      16'(m_wrap));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_clock();
      #1;
      check_all();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b0;
    bus.steps  = 4'd0;
    model_reset();

    // Reset state, before any clock edge
    #2;
    check_all();
    cycles(2);
    reset = 1'b0;

    // 4-step staircase through two wraps: 63,126,189,252
    phase = "steps4";
    bus.steps = 4'd4; bus.enable = 1'b1;
    cycles(4 * D * 2 + 2);

    // 10-step staircase, top level 250
    phase = "steps10";
    bus.steps = 4'd10;
    cycles(10 * D + 2 * D + 4);

    // Mid-ramp change 4 -> 2 takes effect after the ramp completes
    phase = "change4to2";
    bus.enable = 1'b0;
    cycles(1);
    bus.steps = 4'd4; bus.enable = 1'b1;
    cycles(D + 2);
    bus.steps = 4'd2;
    cycles(4 * D + 4 * D);

    // Clamp 15 -> 10
    phase = "steps15";
    bus.steps = 4'd15;
    cycles(2 * D + 10 * D + 2);

    // steps=0 with enable: must stay idle
    phase = "steps0";
    bus.enable = 1'b0;
    cycles(1);
    bus.steps = 4'd0; bus.enable = 1'b1;
    cycles(6);

    // Drop enable at step_idx=2, then re-enable restarts at 63
    phase = "drop_enable";
    bus.steps = 4'd4;
    cycles(2 * D + 2);
    bus.enable = 1'b0;
    cycles(3);
    bus.enable = 1'b1;
    cycles(D + 2);

    // Asynchronous reset mid-dwell: outputs clear before the next edge
    phase = "async_reset";
    cycles(1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cycles(2);
    reset = 1'b0;
    cycles(D + 3);

    // Randomized enable/steps traffic, includes disables coinciding with wraps
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.steps = 4'($urandom_range(0, 15));
      bus.enable = ($urandom_range(0, 24) != 0);
      cycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
